// File: rtl/flash_cmd_pkg.sv
// Shared opcodes, requester op encoding and FSM state enumerations for the
// flash program sequencer and its command issuer.
package flash_cmd_pkg;

    localparam logic [7:0] CMD_RSTEN = 8'h66;
    localparam logic [7:0] CMD_RST   = 8'h99;
    localparam logic [7:0] CMD_WREN  = 8'h06;
    localparam logic [7:0] CMD_PROG  = 8'h02;
    localparam logic [7:0] CMD_ERASE = 8'h20;
    localparam logic [7:0] CMD_RDSR  = 8'h05;
    localparam logic [7:0] CMD_READ  = 8'h03;

    typedef enum logic [1:0] {
        OP_READ     = 2'b00,
        OP_PROGRAM  = 2'b01,
        OP_ERASE_4K = 2'b10,
        OP_RSVD     = 2'b11
    } op_e;

    typedef enum logic [3:0] {
        S_INIT_WAIT,
        S_RSTEN,
        S_RST,
        S_IDLE,
        S_WREN,
        S_PROG,
        S_ERASE,
        S_POLL,
        S_READ,
        S_FINISH
    } seq_state_e;

    typedef enum logic [1:0] {
        ISS_IDLE,
        ISS_SETUP,
        ISS_ACTIVE,
        ISS_GAP
    } iss_state_e;

    // Read-type commands end on RdDataValid, all others on WrDataReady.
    function automatic logic cmd_is_read(input logic [7:0] cmd);
        return (cmd == CMD_RDSR) || (cmd == CMD_READ);
    endfunction

endpackage

// File: rtl/flash_cmd_issue.sv
// Single flash-core command handshake: present command, drop enable, wait for
// the core strobe, release enable and hold it high for the inter-command gap.
module flash_cmd_issue
    import flash_cmd_pkg::*;
#(
    parameter int GAP_CYCLES = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic [7:0]  i_cmd,
    input  logic [21:0] i_addr,
    input  logic [7:0]  i_wdata,
    input  logic        i_is_read,
    output logic        o_done,
    output logic [7:0]  o_byte,
    output logic        o_fen_n,
    output logic [7:0]  o_fcmd,
    output logic [21:0] o_faddr,
    output logic [7:0]  o_fwdata,
    input  logic [7:0]  i_frd,
    input  logic        i_rd_valid,
    input  logic        i_wr_ready
);

    localparam int GAP_LAST = (GAP_CYCLES > 1) ? GAP_CYCLES - 1 : 0;
    localparam int GW       = $clog2(GAP_LAST + 2);

    iss_state_e     r_state;
    iss_state_e     w_next;
    logic           r_fen_n;
    logic [7:0]     r_cmd;
    logic [21:0]    r_addr;
    logic [7:0]     r_wdata;
    logic           r_is_read;
    logic [7:0]     r_byte;
    logic [GW-1:0]  r_gap;
    logic           r_done;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= ISS_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ISS_IDLE:   if (i_start) w_next = ISS_SETUP;
            ISS_SETUP:  w_next = ISS_ACTIVE;
            ISS_ACTIVE: if (r_is_read ? i_rd_valid : i_wr_ready) w_next = ISS_GAP;
            ISS_GAP:    if (r_gap == GW'(GAP_LAST)) w_next = ISS_IDLE;
            default:    w_next = ISS_IDLE;
        endcase
    end

    // Command fields are registered one cycle before enable drops so they are
    // stable for the whole enable-low window.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_fen_n   <= 1'b1;
            r_cmd     <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_is_read <= 1'b0;
            r_byte    <= '0;
            r_gap     <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= (r_state == ISS_GAP) && (w_next == ISS_IDLE);
            case (r_state)
                ISS_IDLE: begin
                    if (i_start) begin
                        r_cmd     <= i_cmd;
                        r_addr    <= i_addr;
                        r_wdata   <= i_wdata;
                        r_is_read <= i_is_read;
                    end
                end
                ISS_SETUP: r_fen_n <= 1'b0;
                ISS_ACTIVE: begin
                    if (w_next == ISS_GAP) begin
                        r_fen_n <= 1'b1;
                        r_gap   <= '0;
                        if (r_is_read) r_byte <= i_frd;
                    end
                end
                ISS_GAP: r_gap <= r_gap + GW'(1);
                default: ;
            endcase
        end
    end

    assign o_done   = r_done;
    assign o_byte   = r_byte;
    assign o_fen_n  = r_fen_n;
    assign o_fcmd   = r_cmd;
    assign o_faddr  = r_addr;
    assign o_fwdata = r_wdata;

endmodule

// File: rtl/flash_prog_sequencer.sv
// Flash init / read / program / 4K-erase sequencer on top of flash_cmd_issue.
// Define FLASH_SEQ_VERIFY_EN to append a readback compare to PROGRAM.
module flash_prog_sequencer
    import flash_cmd_pkg::*;
#(
    parameter int STARTUP_WAIT = 1000,
    parameter int GAP_CYCLES   = 2,
    parameter int POLL_MAX     = 4095
) (
    input  logic        interfaceClk,
    input  logic        reset,
    input  logic        req,
    input  logic [1:0]  op,
    input  logic [21:0] addr,
    input  logic [7:0]  wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [7:0]  rdata,
    output logic        fEnable_n,
    output logic [7:0]  fCommand,
    output logic [21:0] fAddress,
    output logic [7:0]  fData_WR,
    input  logic [7:0]  fData_RD,
    input  logic        RdDataValid,
    input  logic        WrDataReady
);

    localparam int PW = (POLL_MAX > 1) ? $clog2(POLL_MAX + 1) : 1;
    localparam logic [PW-1:0] POLL_SAT  = PW'(POLL_MAX);
    localparam logic [PW-1:0] POLL_LAST = PW'(POLL_MAX - 1);

    seq_state_e     r_state;
    seq_state_e     w_next;
    op_e            r_op;
    logic [21:0]    r_addr;
    logic [7:0]     r_wdata;
    logic           r_err;
    logic [7:0]     r_rdata;
    logic [PW-1:0]  r_poll;
    logic [31:0]    r_wait;
    logic           r_issued;

    logic           w_fin_err;
    logic           w_cmd_state;
    logic           w_start;
    logic [7:0]     w_cmd;
    logic [21:0]    w_cmd_addr;
    logic [7:0]     w_cmd_wdata;
    logic           w_cmd_done;
    logic [7:0]     w_byte;

    always_ff @(posedge interfaceClk or negedge reset) begin
        if (!reset) r_state <= S_INIT_WAIT;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_fin_err = 1'b0;
        case (r_state)
            S_INIT_WAIT: if (r_wait + 32'd1 >= 32'(STARTUP_WAIT)) w_next = S_RSTEN;
            S_RSTEN:     if (w_cmd_done) w_next = S_RST;
            S_RST:       if (w_cmd_done) w_next = S_IDLE;
            S_IDLE: begin
                if (req) begin
                    case (op)
                        OP_READ:     w_next = S_READ;
                        OP_PROGRAM,
                        OP_ERASE_4K: w_next = S_WREN;
                        default: begin
                            w_next    = S_FINISH;
                            w_fin_err = 1'b1;
                        end
                    endcase
                end
            end
            S_WREN:  if (w_cmd_done) w_next = (r_op == OP_PROGRAM) ? S_PROG : S_ERASE;
            S_PROG,
            S_ERASE: if (w_cmd_done) w_next = S_POLL;
            S_POLL: begin
                if (w_cmd_done) begin
                    if (!w_byte[0]) begin
`ifdef FLASH_SEQ_VERIFY_EN
                        w_next = (r_op == OP_PROGRAM) ? S_READ : S_FINISH;
`else
                        w_next = S_FINISH;
`endif
                    end else if (r_poll >= POLL_LAST) begin
                        w_next    = S_FINISH;
                        w_fin_err = 1'b1;
                    end
                end
            end
            S_READ: begin
                if (w_cmd_done) begin
                    w_next = S_FINISH;
`ifdef FLASH_SEQ_VERIFY_EN
                    w_fin_err = (r_op == OP_PROGRAM) && (w_byte != r_wdata);
`endif
                end
            end
            S_FINISH: w_next = S_IDLE;
            default:  w_next = S_INIT_WAIT;
        endcase
    end

    always_comb begin
        w_cmd_state = 1'b1;
        w_cmd       = 8'h00;
        w_cmd_addr  = '0;
        w_cmd_wdata = '0;
        case (r_state)
            S_RSTEN: w_cmd = CMD_RSTEN;
            S_RST:   w_cmd = CMD_RST;
            S_WREN:  w_cmd = CMD_WREN;
            S_PROG: begin
                w_cmd       = CMD_PROG;
                w_cmd_addr  = r_addr;
                w_cmd_wdata = r_wdata;
            end
            S_ERASE: begin
                w_cmd      = CMD_ERASE;
                w_cmd_addr = r_addr;
            end
            S_POLL:  w_cmd = CMD_RDSR;
            S_READ: begin
                w_cmd      = CMD_READ;
                w_cmd_addr = r_addr;
            end
            default: w_cmd_state = 1'b0;
        endcase
    end

    // One start per command; an RDSR reissue re-arms through the done pulse.
    assign w_start = w_cmd_state && !r_issued;

    always_ff @(posedge interfaceClk or negedge reset) begin
        if (!reset) begin
            r_op     <= OP_READ;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_err    <= 1'b0;
            r_rdata  <= '0;
            r_poll   <= '0;
            r_wait   <= '0;
            r_issued <= 1'b0;
        end else begin
            if (r_state == S_INIT_WAIT) r_wait <= r_wait + 32'd1;
            if (r_state == S_IDLE && req) begin
                r_op    <= op_e'(op);
                r_addr  <= addr;
                r_wdata <= wdata;
            end
            if (w_start)         r_issued <= 1'b1;
            else if (w_cmd_done) r_issued <= 1'b0;
            if (r_state != S_POLL)                  r_poll <= '0;
            else if (w_cmd_done && r_poll != POLL_SAT) r_poll <= r_poll + PW'(1);
            if (r_state == S_READ && w_cmd_done) r_rdata <= w_byte;
            if (r_state != S_FINISH && w_next == S_FINISH) r_err <= w_fin_err;
        end
    end

    flash_cmd_issue #(
        .GAP_CYCLES (GAP_CYCLES)
    ) u_issue (
        .i_clk      (interfaceClk),
        .i_rst_n    (reset),
        .i_start    (w_start),
        .i_cmd      (w_cmd),
        .i_addr     (w_cmd_addr),
        .i_wdata    (w_cmd_wdata),
        .i_is_read  (cmd_is_read(w_cmd)),
        .o_done     (w_cmd_done),
        .o_byte     (w_byte),
        .o_fen_n    (fEnable_n),
        .o_fcmd     (fCommand),
        .o_faddr    (fAddress),
        .o_fwdata   (fData_WR),
        .i_frd      (fData_RD),
        .i_rd_valid (RdDataValid),
        .i_wr_ready (WrDataReady)
    );

    assign busy  = !(r_state == S_IDLE || r_state == S_FINISH);
    assign done  = (r_state == S_FINISH);
    assign err   = r_err;
    assign rdata = r_rdata;

endmodule

// File: tb/tb_flash_prog_sequencer.sv
// Self-checking bench for flash_prog_sequencer with a behavioural flash core.
module tb_flash_prog_sequencer;

    localparam int SW   = 20;
    localparam int GAP  = 2;
    localparam int PMAX = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [21:0] addr = '0;
    logic [7:0]  wdata = '0;
    logic        busy, done, err;
    logic [7:0]  rdata;
    logic        fEnable_n;
    logic [7:0]  fCommand;
    logic [21:0] fAddress;
    logic [7:0]  fData_WR;
    logic [7:0]  fData_RD = '0;
    logic        RdDataValid = 1'b0;
    logic        WrDataReady = 1'b0;

    flash_prog_sequencer #(
        .STARTUP_WAIT (SW),
        .GAP_CYCLES   (GAP),
        .POLL_MAX     (PMAX)
    ) dut (
        .interfaceClk (clk),
        .reset        (rst_n),
        .req          (req),
        .op           (op),
        .addr         (addr),
        .wdata        (wdata),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .rdata        (rdata),
        .fEnable_n    (fEnable_n),
        .fCommand     (fCommand),
        .fAddress     (fAddress),
        .fData_WR     (fData_WR),
        .fData_RD     (fData_RD),
        .RdDataValid  (RdDataValid),
        .WrDataReady  (WrDataReady)
    );

    always #5 clk = ~clk;

    logic [7:0]  exp_q[$];
    logic [7:0]  obs_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          wip_left = 0;
    bit          wip_stuck = 1'b0;
    logic [7:0]  mem_byte = 8'h00;
    logic [21:0] cap_addr = '0;
    logic [7:0]  cap_wd = '0;
    int          win_err = 0;
    int          gap_err = 0;
    int          done_cnt = 0;
    int          m_cnt = 0;
    bit          m_fired = 1'b0;

    // Flash core model: strobe the third cycle of each enable-low window.
    always @(posedge clk) begin
        WrDataReady <= 1'b0;
        RdDataValid <= 1'b0;
        if (fEnable_n) begin
            m_cnt   <= 0;
            m_fired <= 1'b0;
        end else begin
            if (m_cnt == 0) begin
                obs_q.push_back(fCommand);
                if (fCommand inside {8'h02, 8'h20, 8'h03}) begin
                    cap_addr <= fAddress;
                    cap_wd   <= fData_WR;
                end
            end
            m_cnt <= m_cnt + 1;
            if (m_cnt == 2 && !m_fired) begin
                m_fired <= 1'b1;
                if (fCommand == 8'h05) begin
                    RdDataValid <= 1'b1;
                    fData_RD    <= (wip_stuck || wip_left > 0) ? 8'h01 : 8'h00;
                    if (!wip_stuck && wip_left > 0) wip_left = wip_left - 1;
                end else if (fCommand == 8'h03) begin
                    RdDataValid <= 1'b1;
                    fData_RD    <= mem_byte;
                end else begin
                    WrDataReady <= 1'b1;
                end
            end
        end
    end

    // Protocol monitor: window closes one cycle after strobe; gap honoured.
    bit strobe_seen = 1'b0;
    int hi_run = 1000;
    always @(posedge clk) begin
        if (strobe_seen && !fEnable_n) win_err++;
        strobe_seen = (WrDataReady || RdDataValid) && !fEnable_n;
        if (fEnable_n) hi_run++;
        else begin
            if (hi_run > 0 && hi_run < GAP) gap_err++;
            hi_run = 0;
        end
    end

    always @(negedge clk) if (done) done_cnt++;

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (fEnable_n !== 1'b1) $display("FAIL reset_fen got=%b exp=1", fEnable_n); else n_pass++;
        n_checks++; if (fCommand !== 8'h00) $display("FAIL reset_fcmd got=%h exp=00", fCommand); else n_pass++;
        n_checks++; if (fAddress !== 22'h0) $display("FAIL reset_faddr got=%h exp=0", fAddress); else n_pass++;
        n_checks++; if (fData_WR !== 8'h00) $display("FAIL reset_fwd got=%h exp=00", fData_WR); else n_pass++;
        n_checks++; if (busy !== 1'b1) $display("FAIL reset_busy got=%b exp=1", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL reset_done got=%b exp=0", done); else n_pass++;
        n_checks++; if (err !== 1'b0) $display("FAIL reset_err got=%b exp=0", err); else n_pass++;
        n_checks++; if (rdata !== 8'h00) $display("FAIL reset_rdata got=%h exp=00", rdata); else n_pass++;
    endtask

    task automatic test_init();
        int c = 0;
        int first_fall = -1;
        logic [7:0] e, o;
        exp_q = {};
        obs_q = {};
        exp_q.push_back(8'h66);
        exp_q.push_back(8'h99);
        rst_n = 1'b1;
        while (busy && c < 2000) begin
            @(negedge clk);
            c++;
            if (!fEnable_n && first_fall < 0) first_fall = c;
        end
        n_checks++; if (busy !== 1'b0) $display("FAIL init_busy_timeout got=%b exp=0", busy); else n_pass++;
        n_checks++; if (first_fall < SW) $display("FAIL init_startup_wait got=%0d exp>=%0d", first_fall, SW); else n_pass++;
        n_checks++; if (obs_q.size() != exp_q.size()) $display("FAIL init_cmd_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); else n_pass++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++; if (o !== e) $display("FAIL init_cmd got=%h exp=%h", o, e); else n_pass++;
        end
    endtask

    task automatic test_program();
        int c = 0;
        logic e_err, e_busy;
        logic [7:0] e, o;
        exp_q = {};
        obs_q = {};
        wip_left  = 3;
        wip_stuck = 1'b0;
        mem_byte  = 8'h05;
        exp_q.push_back(8'h06);
        exp_q.push_back(8'h02);
        repeat (4) exp_q.push_back(8'h05);
`ifdef FLASH_SEQ_VERIFY_EN
        exp_q.push_back(8'h03);
`endif
        done_cnt = 0;
        @(negedge clk);
        req = 1'b1; op = 2'b01; addr = 22'h00A000; wdata = 8'h05;
        @(negedge clk);
        req = 1'b0;
        n_checks++; if (busy !== 1'b1) $display("FAIL prog_busy_after_req got=%b exp=1", busy); else n_pass++;
        while (!done && c < 3000) begin @(negedge clk); c++; end
        e_err = err; e_busy = busy;
        n_checks++; if (done !== 1'b1) $display("FAIL prog_done_timeout got=%b exp=1", done); else n_pass++;
        n_checks++; if (e_err !== 1'b0) $display("FAIL prog_err got=%b exp=0", e_err); else n_pass++;
        n_checks++; if (e_busy !== 1'b0) $display("FAIL prog_busy_at_done got=%b exp=0", e_busy); else n_pass++;
        repeat (5) @(negedge clk);
        n_checks++; if (done_cnt != 1) $display("FAIL prog_done_pulses got=%0d exp=1", done_cnt); else n_pass++;
`ifdef FLASH_SEQ_VERIFY_EN
        n_checks++; if (rdata !== 8'h05) $display("FAIL prog_rdata got=%h exp=05", rdata); else n_pass++;
`else
        n_checks++; if (rdata !== 8'h00) $display("FAIL prog_rdata_unchanged got=%h exp=00", rdata); else n_pass++;
`endif
        n_checks++; if (obs_q.size() != exp_q.size()) $display("FAIL prog_cmd_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); else n_pass++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++; if (o !== e) $display("FAIL prog_cmd got=%h exp=%h", o, e); else n_pass++;
        end
    endtask

    task automatic test_read();
        int c = 0;
        logic e_err;
        exp_q = {};
        obs_q = {};
        mem_byte = 8'h05;
        exp_q.push_back(8'h03);
        done_cnt = 0;
        @(negedge clk);
        req = 1'b1; op = 2'b00; addr = 22'h00A000; wdata = 8'h00;
        @(negedge clk);
        req = 1'b0;
        while (!done && c < 3000) begin @(negedge clk); c++; end
        e_err = err;
        n_checks++; if (done !== 1'b1) $display("FAIL read_done_timeout got=%b exp=1", done); else n_pass++;
        n_checks++; if (e_err !== 1'b0) $display("FAIL read_err got=%b exp=0", e_err); else n_pass++;
        n_checks++; if (rdata !== 8'h05) $display("FAIL read_rdata got=%h exp=05", rdata); else n_pass++;
        n_checks++; if (cap_addr !== 22'h00A000) $display("FAIL read_addr got=%h exp=00a000", cap_addr); else n_pass++;
        repeat (5) @(negedge clk);
        n_checks++; if (done_cnt != 1) $display("FAIL read_done_pulses got=%0d exp=1", done_cnt); else n_pass++;
        n_checks++; if (obs_q.size() != 1) $display("FAIL read_cmd_count got=%0d exp=1", obs_q.size()); else n_pass++;
        if (obs_q.size() > 0) begin
            n_checks++; if (obs_q[0] !== exp_q[0]) $display("FAIL read_cmd got=%h exp=%h", obs_q[0], exp_q[0]); else n_pass++;
        end
    endtask

    task automatic test_reserved();
        int c = 0;
        logic e_err;
        obs_q = {};
        done_cnt = 0;
        @(negedge clk);
        req = 1'b1; op = 2'b11; addr = 22'h3FFFFF; wdata = 8'hAA;
        @(negedge clk);
        req = 1'b0;
        while (!done && c < 100) begin @(negedge clk); c++; end
        e_err = err;
        n_checks++; if (done !== 1'b1) $display("FAIL rsvd_done_timeout got=%b exp=1", done); else n_pass++;
        n_checks++; if (e_err !== 1'b1) $display("FAIL rsvd_err got=%b exp=1", e_err); else n_pass++;
        repeat (10) @(negedge clk);
        n_checks++; if (obs_q.size() != 0) $display("FAIL rsvd_no_cmd got=%0d exp=0", obs_q.size()); else n_pass++;
        n_checks++; if (rdata !== 8'h05) $display("FAIL rsvd_rdata_kept got=%h exp=05", rdata); else n_pass++;
        n_checks++; if (done_cnt != 1) $display("FAIL rsvd_done_pulses got=%0d exp=1", done_cnt); else n_pass++;
    endtask

    // Erase with a req fired mid-operation (ignored), then a read right after.
    task automatic test_back_to_back();
        int c = 0;
        logic e_err;
        logic [7:0] e, o;
        exp_q = {};
        obs_q = {};
        wip_left = 0;
        mem_byte = 8'h3C;
        exp_q.push_back(8'h06);
        exp_q.push_back(8'h20);
        exp_q.push_back(8'h05);
        @(negedge clk);
        req = 1'b1; op = 2'b10; addr = 22'h012000; wdata = 8'h00;
        @(negedge clk);
        req = 1'b1; op = 2'b00; addr = 22'h000123;
        repeat (3) @(negedge clk);
        req = 1'b0;
        while (!done && c < 3000) begin @(negedge clk); c++; end
        e_err = err;
        n_checks++; if (done !== 1'b1) $display("FAIL erase_done_timeout got=%b exp=1", done); else n_pass++;
        n_checks++; if (e_err !== 1'b0) $display("FAIL erase_err got=%b exp=0", e_err); else n_pass++;
        n_checks++; if (cap_addr !== 22'h012000) $display("FAIL erase_addr got=%h exp=012000", cap_addr); else n_pass++;
        exp_q.push_back(8'h03);
        @(negedge clk);
        req = 1'b1; op = 2'b00; addr = 22'h000456;
        @(negedge clk);
        req = 1'b0;
        c = 0;
        while (!done && c < 3000) begin @(negedge clk); c++; end
        n_checks++; if (rdata !== 8'h3C) $display("FAIL b2b_read_rdata got=%h exp=3c", rdata); else n_pass++;
        repeat (3) @(negedge clk);
        n_checks++; if (obs_q.size() != exp_q.size()) $display("FAIL b2b_cmd_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); else n_pass++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++; if (o !== e) $display("FAIL b2b_cmd got=%h exp=%h", o, e); else n_pass++;
        end
    endtask

    task automatic test_poll_timeout();
        int c = 0;
        int n_rdsr = 0;
        logic e_err;
        logic [7:0] e, o;
        exp_q = {};
        obs_q = {};
        wip_stuck = 1'b1;
        exp_q.push_back(8'h06);
        exp_q.push_back(8'h02);
        repeat (PMAX) exp_q.push_back(8'h05);
        @(negedge clk);
        req = 1'b1; op = 2'b01; addr = 22'h001234; wdata = 8'h77;
        @(negedge clk);
        req = 1'b0;
        while (!done && c < 5000) begin @(negedge clk); c++; end
        e_err = err;
        n_checks++; if (done !== 1'b1) $display("FAIL poll_done_timeout got=%b exp=1", done); else n_pass++;
        n_checks++; if (e_err !== 1'b1) $display("FAIL poll_err got=%b exp=1", e_err); else n_pass++;
        wip_stuck = 1'b0;
        repeat (3) @(negedge clk);
        foreach (obs_q[i]) if (obs_q[i] == 8'h05) n_rdsr++;
        n_checks++; if (n_rdsr != PMAX) $display("FAIL poll_rdsr_count got=%0d exp=%0d", n_rdsr, PMAX); else n_pass++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++; if (o !== e) $display("FAIL poll_cmd got=%h exp=%h", o, e); else n_pass++;
        end
    endtask

`ifdef FLASH_SEQ_VERIFY_EN
    task automatic test_verify();
        int c = 0;
        logic e_err;
        obs_q = {};
        wip_left = 0;
        mem_byte = 8'h04;
        @(negedge clk);
        req = 1'b1; op = 2'b01; addr = 22'h00A000; wdata = 8'h05;
        @(negedge clk);
        req = 1'b0;
        while (!done && c < 3000) begin @(negedge clk); c++; end
        e_err = err;
        n_checks++; if (e_err !== 1'b1) $display("FAIL verify_err got=%b exp=1", e_err); else n_pass++;
        n_checks++; if (rdata !== 8'h04) $display("FAIL verify_rdata got=%h exp=04", rdata); else n_pass++;
        n_checks++; if (obs_q.size() != 4) $display("FAIL verify_cmd_count got=%0d exp=4", obs_q.size()); else n_pass++;
    endtask
`endif

    task automatic test_reset_mid_cmd();
        int c = 0;
        logic [7:0] e, o;
        obs_q = {};
        wip_left = 0;
        @(negedge clk);
        req = 1'b1; op = 2'b01; addr = 22'h002000; wdata = 8'h11;
        @(negedge clk);
        req = 1'b0;
        while (!(fCommand == 8'h02 && !fEnable_n) && c < 500) begin @(negedge clk); c++; end
        n_checks++; if (fEnable_n !== 1'b0) $display("FAIL rstmid_prog_window got=%b exp=0", fEnable_n); else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (fEnable_n !== 1'b1) $display("FAIL rstmid_fen_immediate got=%b exp=1", fEnable_n); else n_pass++;
        n_checks++; if (busy !== 1'b1) $display("FAIL rstmid_busy got=%b exp=1", busy); else n_pass++;
        repeat (3) @(negedge clk);
        obs_q = {};
        exp_q = {};
        exp_q.push_back(8'h66);
        exp_q.push_back(8'h99);
        rst_n = 1'b1;
        c = 0;
        while (busy && c < 2000) begin @(negedge clk); c++; end
        repeat (5) @(negedge clk);
        n_checks++; if (busy !== 1'b0) $display("FAIL rstmid_reinit_timeout got=%b exp=0", busy); else n_pass++;
        n_checks++; if (obs_q.size() != exp_q.size()) $display("FAIL rstmid_cmd_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); else n_pass++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++; if (o !== e) $display("FAIL rstmid_cmd got=%h exp=%h", o, e); else n_pass++;
        end
    endtask

    task automatic test_protocol();
        n_checks++; if (win_err != 0) $display("FAIL window_close got=%0d exp=0", win_err); else n_pass++;
        n_checks++; if (gap_err != 0) $display("FAIL enable_gap got=%0d exp=0", gap_err); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_init();
        test_program();
        test_read();
        test_reserved();
        test_back_to_back();
        test_poll_timeout();
`ifdef FLASH_SEQ_VERIFY_EN
        test_verify();
`endif
        test_reset_mid_cmd();
        test_protocol();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/flash_prog_sequencer.md
FLASH_PROG_SEQUENCER -- requirements
Module: flash_prog_sequencer

Interface
REQ-001 SHALL have parameter STARTUP_WAIT, default 1000, meaning interfaceClk cycles held idle after reset before the flash reset sequence.
REQ-002 SHALL have parameter GAP_CYCLES, default 2, meaning minimum cycles fEnable_n stays high between flash commands.
REQ-003 SHALL have parameter POLL_MAX, default 4095, meaning maximum RDSR polls before a timeout error.
REQ-004 SHALL have port interfaceClk  in  1  the only clock, shared with the flash core interface side.
REQ-005 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port req  in  1  requester start strobe.
REQ-007 SHALL have port op  in  2  requester opcode: 00 READ, 01 PROGRAM, 10 ERASE_4K, 11 reserved.
REQ-008 SHALL have port addr  in  22  flash byte address.
REQ-009 SHALL have port wdata  in  8  program byte.
REQ-010 SHALL have port busy  out  1  operation in progress or init not finished.
REQ-011 SHALL have port done  out  1  one-cycle completion pulse.
REQ-012 SHALL have port err  out  1  status of the last operation, valid with done.
REQ-013 SHALL have port rdata  out  8  byte returned by READ.
REQ-014 SHALL have flash-core ports: fEnable_n out 1; fCommand out 8; fAddress out 22; fData_WR out 8; fData_RD in 8; RdDataValid in 1; WrDataReady in 1.

Function
REQ-015 SHALL sequence states INIT_WAIT -> RSTEN(0x66) -> RST(0x99) -> IDLE, then serve requests through WREN(0x06), PROG(0x02), ERASE(0x20), POLL(RDSR 0x05), READ(0x03), FINISH.
REQ-016 SHALL issue each command by driving fCommand/fAddress/fData_WR stable, then fEnable_n=0, and holding them until the ending event.
REQ-017 SHALL end a write-type command (RSTEN, RST, WREN, PROG, ERASE) by setting fEnable_n=1 in the cycle after WrDataReady=1.
REQ-018 SHALL end a read-type command (RDSR, READ) by capturing fData_RD on the first RdDataValid=1 and setting fEnable_n=1 in the next cycle.
REQ-019 SHALL hold fEnable_n high for at least GAP_CYCLES cycles between consecutive commands.
REQ-020 SHALL accept req only in IDLE, latching op/addr/wdata that cycle, and SHALL assert busy in the next cycle; req while busy SHALL be ignored.
REQ-021 PROGRAM SHALL run WREN, PROG, then POLL; ERASE_4K SHALL run WREN, ERASE, then POLL; READ SHALL run READ only.
REQ-022 POLL SHALL reissue RDSR while status bit0 (WIP)=1, and SHALL go to FINISH with err=1 after POLL_MAX polls with WIP still 1.
REQ-023 op=11 SHALL go directly to FINISH with err=1, issuing no flash command.
REQ-024 FINISH SHALL pulse done for exactly one cycle, with busy=0 in that same cycle, and return to IDLE.
REQ-025 rdata SHALL update only on READ completion; err SHALL update only in FINISH.
REQ-026 The poll counter SHALL saturate and never wrap.

Reset
REQ-027 Reset SHALL asynchronously force state INIT_WAIT, fEnable_n=1, fCommand=0, fAddress=0, fData_WR=0, busy=1, done=0, err=0, rdata=0.
REQ-028 Reset asserted mid-command SHALL raise fEnable_n in the same cycle and discard the pending request; after release the full init sequence SHALL rerun.

Configuration
REQ-029 With FLASH_SEQ_VERIFY_EN defined, PROGRAM SHALL append a READ of addr after POLL and set err=1 if the byte read differs from wdata, with rdata=byte read.
REQ-030 With FLASH_SEQ_VERIFY_EN undefined, PROGRAM SHALL end after POLL and rdata SHALL remain unchanged.

Structure
REQ-031 Opcodes, the op encoding and the state enumeration SHALL live in shared package flash_cmd_pkg.
REQ-032 The command handshake (drive, wait for strobe, release, gap) SHALL be sub-module flash_cmd_issue, which the sequencer drives with start/cmd/is_read and receives done/byte from.

Verification
REQ-033 Reset release -> after STARTUP_WAIT cycles, fCommand 0x66 then 0x99 are issued, each enable window closed one cycle after WrDataReady; busy falls to 0.
REQ-034 req, op=01, addr=0x00A000, wdata=0x05, flash model WIP=1 for 3 polls -> commands 0x06, 0x02, 0x05 x4; done pulses once with err=0.
REQ-035 req, op=00, addr=0x00A000, model returns 0x05 -> one 0x03 command, rdata=0x05, err=0, done single pulse.
REQ-036 Model WIP stuck at 1 with POLL_MAX=8 -> exactly 8 RDSR commands, then done with err=1.
REQ-037 Reset asserted during the PROG enable window -> fEnable_n=1 immediately; after release the init sequence reruns with no PROG reissue.
REQ-038 With FLASH_SEQ_VERIFY_EN defined and the model returning 0x04 -> program 0x05 followed by a readback; err=1 and rdata=0x04.
